uart_rx_buf: RTL and testbench

UART_RX_BUF -- requirements
Module: uart_rx_buf

---
 rtl/uart_rx_buf_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx_buf.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_buf.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_buf_pkg.sv
// Shared UART definitions: bit timing default, field widths and receiver FSM encodings.
package uart_rx_buf_pkg;

  // 25 MHz clock / 115200 baud
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_IDX_W = 3;

  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [BIT_IDX_W-1:0] bit_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_Async,
  output logic o_Sync
);

  logic meta_q;

  // Metastability chain: first flop may go metastable, second resolves it
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q <= RST_VAL;
      o_Sync <= RST_VAL;
    end else begin
      meta_q <= i_Async;
      o_Sync <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver with a one-byte holding register, valid/ready handshake,
// frame-error pulse and sticky overrun flag.
module uart_rx_buf
  import uart_rx_buf_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic              i_Clock,
  input  logic              i_Rst_L,
  input  logic              i_RX_Serial,
  input  logic              i_RX_Ready,
  input  logic              i_Err_Clr,
  output logic              o_RX_Valid,
  output logic [DATA_W-1:0] o_RX_Byte,
  output logic              o_Frame_Err,
  output logic              o_Overrun
);

  // Counter terminal values: full bit period and half bit period (start-bit centre)
  localparam cnt_t     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam cnt_t     HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);
  localparam bit_idx_t IDX_LAST  = BIT_IDX_W'(DATA_W - 1);

  logic      rx_sync;
  rx_state_e state_q;
  rx_state_e state_d;
  cnt_t      cnt_q;
  bit_idx_t  bit_idx_q;
  data_t     shift_q;
  logic      valid_q;
  data_t     byte_q;
  logic      frame_err_q;
  logic      overrun_q;

  logic cnt_clr_c;
  logic cnt_inc_c;
  logic bit_clr_c;
  logic shift_c;
  logic stop_ok_c;
  logic stop_bad_c;
  logic accept_c;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_Clock (i_Clock),
    .i_Rst_L (i_Rst_L),
    .i_Async (i_RX_Serial),
    .o_Sync  (rx_sync)
  );

  // FSM state register
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_sync) state_d = ST_START;
      end
      ST_START: begin
        // Low at mid start bit confirms a real frame; high means a glitch
        if (cnt_q == HALF_LAST) state_d = rx_sync ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if ((cnt_q == BIT_LAST) && (bit_idx_q == IDX_LAST)) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Return to IDLE at mid stop bit so the next start edge is not missed
        if (cnt_q == BIT_LAST) state_d = rx_sync ? ST_IDLE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (rx_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output decode: counter, shift and stop-bit strobes
  always_comb begin
    cnt_clr_c  = 1'b0;
    cnt_inc_c  = 1'b0;
    bit_clr_c  = 1'b0;
    shift_c    = 1'b0;
    stop_ok_c  = 1'b0;
    stop_bad_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_clr_c = 1'b1;
        bit_clr_c = 1'b1;
      end
      ST_START: begin
        bit_clr_c = 1'b1;
        if (cnt_q == HALF_LAST) cnt_clr_c = 1'b1;
        else                    cnt_inc_c = 1'b1;
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_clr_c = 1'b1;
          shift_c   = 1'b1;
        end else begin
          cnt_inc_c = 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_clr_c  = 1'b1;
          stop_ok_c  = rx_sync;
          stop_bad_c = ~rx_sync;
        end else begin
          cnt_inc_c = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_clr_c = 1'b1;
      end
      default: begin
        cnt_clr_c = 1'b1;
        bit_clr_c = 1'b1;
      end
    endcase
  end

  // A good byte is taken when the holding register is empty or being drained now
  assign accept_c = stop_ok_c & (~valid_q | i_RX_Ready);

  // Bit-clock counter, bit index and LSB-first shift register
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      if (cnt_clr_c)      cnt_q <= '0;
      else if (cnt_inc_c) cnt_q <= cnt_q + CNT_W'(1);

      if (bit_clr_c)    bit_idx_q <= '0;
      else if (shift_c) bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);

      if (shift_c) shift_q <= {rx_sync, shift_q[DATA_W-1:1]};
    end
  end

  // Holding register with valid/ready handshake and error flags
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      valid_q     <= 1'b0;
      byte_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (accept_c) begin
        valid_q <= 1'b1;
        byte_q  <= shift_q;
      end else if (valid_q && i_RX_Ready) begin
        valid_q <= 1'b0;
      end

      frame_err_q <= stop_bad_c;

      // A fresh overrun takes priority over a clear in the same cycle
      if (stop_ok_c && !accept_c) overrun_q <= 1'b1;
      else if (i_Err_Clr)         overrun_q <= 1'b0;
    end
  end

  assign o_RX_Valid  = valid_q;
  assign o_RX_Byte   = byte_q;
  assign o_Frame_Err = frame_err_q;
  assign o_Overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed self-checking bench for uart_rx_buf at 8 clocks per bit.
module tb_uart_rx_buf;
  import uart_rx_buf_pkg::*;

  localparam int C = 8;

  logic       i_Clock;
  logic       i_Rst_L;
  logic       i_RX_Serial;
  logic       i_RX_Ready;
  logic       i_Err_Clr;
  logic       o_RX_Valid;
  logic [7:0] o_RX_Byte;
  logic       o_Frame_Err;
  logic       o_Overrun;

  int   n_checks;
  int   n_fail;
  int   valid_cyc;
  int   valid_rise;
  int   fe_cyc;
  logic valid_d;
  logic [7:0] last_byte;
  logic rdy_base;

  int base_cyc;
  int base_rise;
  int base_fe;

  uart_rx_buf #(
    .CLKS_PER_BIT (C)
  ) dut (
    .i_Clock     (i_Clock),
    .i_Rst_L     (i_Rst_L),
    .i_RX_Serial (i_RX_Serial),
    .i_RX_Ready  (i_RX_Ready),
    .i_Err_Clr   (i_Err_Clr),
    .o_RX_Valid  (o_RX_Valid),
    .o_RX_Byte   (o_RX_Byte),
    .o_Frame_Err (o_Frame_Err),
    .o_Overrun   (o_Overrun)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  // Output event log, sampled on the falling edge
  initial begin
    valid_cyc  = 0;
    valid_rise = 0;
    fe_cyc     = 0;
    valid_d    = 1'b0;
    last_byte  = 8'h00;
  end
  always @(negedge i_Clock) begin
    if (o_RX_Valid) valid_cyc = valid_cyc + 1;
    if (o_RX_Valid && !valid_d) begin
      valid_rise = valid_rise + 1;
      last_byte  = o_RX_Byte;
    end
    if (o_Frame_Err) fe_cyc = fe_cyc + 1;
    valid_d = o_RX_Valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_Clock);
      i_RX_Serial = 1'b1;
      i_RX_Ready  = rdy_base;
      i_Err_Clr   = 1'b0;
    end
  endtask

  task automatic snap();
    base_cyc  = valid_cyc;
    base_rise = valid_rise;
    base_fe   = fe_cyc;
  endtask

  // One 8N1 frame; optional single-cycle ready/clear strobes and a reset window at bit-time k
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int rdy_k, input int clr_k, input int rst_k);
    int bitpos;
    for (int k = 0; k < 10 * C; k++) begin
      @(negedge i_Clock);
      if (rst_k >= 0 && k == rst_k + 1) begin
        check("rst_valid",     32'(o_RX_Valid),  32'h0);
        check("rst_byte",      32'(o_RX_Byte),   32'h0);
        check("rst_overrun",   32'(o_Overrun),   32'h0);
        check("rst_frame_err", 32'(o_Frame_Err), 32'h0);
        check("rst_state",     32'(dut.state_q), 32'(ST_IDLE));
      end
      if (rst_k >= 0 && k == rst_k)     i_Rst_L = 1'b0;
      if (rst_k >= 0 && k == rst_k + 4) i_Rst_L = 1'b1;
      bitpos = k / C;
      if (bitpos == 0)      i_RX_Serial = 1'b0;
      else if (bitpos == 9) i_RX_Serial = stop_bit;
      else                  i_RX_Serial = b[bitpos-1];
      i_RX_Ready = (k == rdy_k) ? 1'b1 : rdy_base;
      i_Err_Clr  = (k == clr_k) ? 1'b1 : 1'b0;
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rdy_base    = 1'b0;
    i_Rst_L     = 1'b0;
    i_RX_Serial = 1'b1;
    i_RX_Ready  = 1'b0;
    i_Err_Clr   = 1'b0;

    // Reset values
    repeat (3) @(negedge i_Clock);
    check("init_valid",     32'(o_RX_Valid),  32'h0);
    check("init_byte",      32'(o_RX_Byte),   32'h0);
    check("init_frame_err", 32'(o_Frame_Err), 32'h0);
    check("init_overrun",   32'(o_Overrun),   32'h0);
    i_Rst_L = 1'b1;
    idle(5);

    // 0xA5 with consumer always ready: single-cycle valid
    rdy_base = 1'b1;
    snap();
    send_frame(8'hA5, 1'b1, -1, -1, -1);
    idle(12);
    check("a5_valid_cycles", 32'(valid_cyc - base_cyc),  32'd1);
    check("a5_byte_seen",    32'(last_byte),             32'hA5);
    check("a5_byte_hold",    32'(o_RX_Byte),             32'hA5);
    check("a5_frame_err",    32'(fe_cyc - base_fe),      32'd0);
    check("a5_overrun",      32'(o_Overrun),             32'h0);

    // 3-cycle glitch is rejected, then 0x3C received
    snap();
    for (int i = 0; i < 3; i++) begin
      @(negedge i_Clock);
      i_RX_Serial = 1'b0;
    end
    idle(12);
    check("glitch_no_valid", 32'(valid_rise - base_rise), 32'd0);
    check("glitch_state",    32'(dut.state_q),            32'(ST_IDLE));
    send_frame(8'h3C, 1'b1, -1, -1, -1);
    idle(12);
    check("glitch_3c_rise", 32'(valid_rise - base_rise), 32'd1);
    check("glitch_3c_byte", 32'(last_byte),              32'h3C);

    // Bad stop bit, line held low, then 0x55
    snap();
    send_frame(8'h3C, 1'b0, -1, -1, -1);
    for (int i = 0; i < 20; i++) begin
      @(negedge i_Clock);
      i_RX_Serial = 1'b0;
    end
    idle(12);
    check("ferr_pulse",    32'(fe_cyc - base_fe),        32'd1);
    check("ferr_no_valid", 32'(valid_rise - base_rise),  32'd0);
    send_frame(8'h55, 1'b1, -1, -1, -1);
    idle(12);
    check("ferr_55_rise", 32'(valid_rise - base_rise), 32'd1);
    check("ferr_55_byte", 32'(last_byte),              32'h55);

    // Back-to-back 0x11, 0x22 with consumer stalled
    rdy_base = 1'b0;
    snap();
    send_frame(8'h11, 1'b1, -1, -1, -1);
    check("ovr_pre_flag", 32'(o_Overrun), 32'h0);
    send_frame(8'h22, 1'b1, -1, -1, -1);
    idle(12);
    check("ovr_valid", 32'(o_RX_Valid),              32'h1);
    check("ovr_byte",  32'(o_RX_Byte),               32'h11);
    check("ovr_flag",  32'(o_Overrun),               32'h1);
    check("ovr_rise",  32'(valid_rise - base_rise),  32'd1);
    @(negedge i_Clock);
    i_Err_Clr = 1'b1;
    @(negedge i_Clock);
    i_Err_Clr = 1'b0;
    check("ovr_cleared", 32'(o_Overrun),  32'h0);
    check("ovr_still_v", 32'(o_RX_Valid), 32'h1);

    // Ready coincides with the stop sample: replace, no overrun
    snap();
    send_frame(8'h77, 1'b1, 10 * C - 2, -1, -1);
    idle(12);
    check("swap_valid",   32'(o_RX_Valid),        32'h1);
    check("swap_byte",    32'(o_RX_Byte),         32'h77);
    check("swap_overrun", 32'(o_Overrun),         32'h0);
    check("swap_ferr",    32'(fe_cyc - base_fe),  32'd0);

    // Clear coincides with an overrun event: overrun wins
    send_frame(8'h99, 1'b1, -1, 10 * C - 2, -1);
    idle(12);
    check("race_overrun", 32'(o_Overrun), 32'h1);
    check("race_byte",    32'(o_RX_Byte), 32'h77);

    // Reset during bit 4 of 0xF0, then 0x0F
    snap();
    send_frame(8'hF0, 1'b1, -1, -1, 5 * C + 2);
    idle(12);
    check("rstf_no_valid", 32'(valid_rise - base_rise), 32'd0);
    rdy_base = 1'b1;
    send_frame(8'h0F, 1'b1, -1, -1, -1);
    idle(12);
    check("rstf_rise",    32'(valid_rise - base_rise), 32'd1);
    check("rstf_byte",    32'(last_byte),              32'h0F);
    check("rstf_drained", 32'(o_RX_Valid),             32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
